// File: rtl/throw_launch_ctl.sv
// ============================================================================
// Module   : throw_launch_ctl
// Purpose  : Per-player throw launcher. Converts a mouse-button hold into a
//            ping-pong force meter and, on release, drives the enable /
//            throw_force handshake to the trajectory controller until the
//            throw retires, then pulses turn_over.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module throw_launch_ctl #(
   parameter int CHARGE_DIV     = 65000,
   parameter int FORCE_MIN      = 64,
   parameter int FORCE_MAX      = 1023,
   parameter int LAUNCH_TIMEOUT = 650000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       my_turn,
   input  logic       btn,
   input  logic       throw_done,
   input  logic       is_throwing,
   output logic       enable,
   output logic [9:0] throw_force,
   output logic       charging,
   output logic       turn_over
);

   localparam int PW = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
   localparam int TW = (LAUNCH_TIMEOUT > 1) ? $clog2(LAUNCH_TIMEOUT) : 1;

   localparam logic [9:0]    F_MIN    = 10'(FORCE_MIN);
   localparam logic [9:0]    F_MAX    = 10'(FORCE_MAX);
   localparam logic [PW-1:0] PRE_LAST = PW'(CHARGE_DIV - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(LAUNCH_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_WAIT    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_CHARGE  = 3'd2,
      ST_LAUNCH  = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   state_t        state;
   logic          dir_up;
   logic [PW-1:0] prescale;
   logic [TW-1:0] launch_cnt;

   // Flight status is informational only; it never steers the state machine.
   logic unused_is_throwing;
   assign unused_is_throwing = is_throwing;

   // Launch state machine; throw_force doubles as the meter register so the
   // value shown while charging is exactly the value frozen at release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_WAIT;
         dir_up      <= 1'b1;
         prescale    <= '0;
         launch_cnt  <= '0;
         enable      <= 1'b0;
         throw_force <= F_MIN;
         charging    <= 1'b0;
         turn_over   <= 1'b0;
      end else begin
         turn_over <= 1'b0;
         case (state)
            ST_WAIT: begin
               // A button already held at turn start must be released first.
               if (my_turn && !btn) begin
                  state <= ST_ARMED;
               end
            end

            ST_ARMED: begin
               if (!my_turn) begin
                  state <= ST_WAIT;
               end else if (btn) begin
                  state       <= ST_CHARGE;
                  charging    <= 1'b1;
                  throw_force <= F_MIN;
                  dir_up      <= 1'b1;
                  prescale    <= '0;
               end
            end

            ST_CHARGE: begin
               if (!my_turn) begin
                  // Abort: no launch, no turn_over.
                  state       <= ST_WAIT;
                  charging    <= 1'b0;
                  throw_force <= F_MIN;
               end else if (!btn) begin
                  // Release: meter freezes at its current (pre-step) value.
                  state      <= ST_LAUNCH;
                  charging   <= 1'b0;
                  enable     <= 1'b1;
                  launch_cnt <= '0;
               end else if (prescale == PRE_LAST) begin
                  prescale <= '0;
                  if (dir_up) begin
                     if (throw_force == F_MAX) begin
                        dir_up      <= 1'b0;
                        throw_force <= F_MAX - 10'd1;
                     end else begin
                        throw_force <= throw_force + 10'd1;
                     end
                  end else begin
                     if (throw_force == F_MIN) begin
                        dir_up      <= 1'b1;
                        throw_force <= F_MIN + 10'd1;
                     end else begin
                        throw_force <= throw_force - 10'd1;
                     end
                  end
               end else begin
                  prescale <= prescale + PW'(1);
               end
            end

            ST_LAUNCH: begin
               // my_turn is ignored from here on: a started throw completes.
               if (throw_done || (launch_cnt == TO_LAST)) begin
                  state      <= ST_RELEASE;
                  enable     <= 1'b0;
                  launch_cnt <= '0;
               end else begin
                  launch_cnt <= launch_cnt + TW'(1);
               end
            end

            ST_RELEASE: begin
               if (!throw_done) begin
                  state       <= ST_WAIT;
                  turn_over   <= 1'b1;
                  throw_force <= F_MIN;
               end
            end

            default: begin
               state       <= ST_WAIT;
               enable      <= 1'b0;
               charging    <= 1'b0;
               throw_force <= F_MIN;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
